// File: rtl/multicycle_sequencer.sv
// Purpose : multi-cycle control FSM for the 16-bit MiniMIPS datapath; sequences
//           fetch/decode/execute/mem/writeback and drives datapath enables.
// Latency : branch 3, R/I-type and sw 4, lw 5, NOP 2 cycles with zero wait states.
// Backpressure: stalls in FETCH until imem_ready and in MEM until dmem_ready;
//           MEM_TIMEOUT consecutive not-ready cycles push the FSM into ERROR.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             leaves IDLE
//   opcode, zero      instruction[15:12] (valid in DECODE), ALU zero flag
//   imem_ready,
//   dmem_ready        memory handshakes
//   imem_req .. pc_src  datapath / memory control strobes
//   busy, halted, error status
//   instr_count       retired-instruction counter (one per pc_write)

module multicycle_sequencer #(
  parameter int COUNT_WIDTH = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [3:0]             opcode,
  input  logic                   zero,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
  output logic                   imem_req,
  output logic                   ir_load,
  output logic                   reg_dest,
  output logic                   alu_src,
  output logic [2:0]             alu_op,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic                   busy,
  output logic                   halted,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_ORI   = 4'b0011;
  localparam logic [3:0] OP_NORI  = 4'b0100;
  localparam logic [3:0] OP_BEQ   = 4'b0101;
  localparam logic [3:0] OP_BNE   = 4'b0110;
  localparam logic [3:0] OP_SLTI  = 4'b0111;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1001;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // Last allowed value of the wait counter; one more not-ready cycle is a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT, S_ERROR
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] op_q;
  logic [7:0] wait_cnt;
  logic       wait_hit;
  logic       dec_nop;

  // ALU-side decode of the latched opcode, held through EXECUTE/MEM/WRITEBACK.
  logic [2:0] dec_alu_op;
  logic       dec_alu_src;
  logic       dec_reg_dest;

  assign wait_hit = (wait_cnt == WAIT_LAST);
  // 1010..1110 retire as no-ops straight from DECODE.
  assign dec_nop  = (opcode >= 4'b1010) && (opcode <= 4'b1110);

  // State register, latched opcode and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= 4'b0000;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        op_q <= opcode;
      end
      // Counts consecutive not-ready cycles; any other state or a ready cycle
      // clears it, so it is always zero on entry to FETCH or MEM.
      if ((state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  // Retired-instruction counter: every pc_write retires exactly one instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (pc_write) begin
      instr_count <= instr_count + COUNT_WIDTH'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready)    state_nxt = S_DECODE;
        else if (wait_hit) state_nxt = S_ERROR;
      end
      S_DECODE: begin
        if (opcode == OP_HALT) state_nxt = S_HALT;
        else if (dec_nop)      state_nxt = S_FETCH;
        else                   state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (op_q == OP_BEQ || op_q == OP_BNE)     state_nxt = S_FETCH;
        else if (op_q == OP_LW || op_q == OP_SW)  state_nxt = S_MEM;
        else                                      state_nxt = S_WRITEBACK;
      end
      S_MEM: begin
        if (dmem_ready)    state_nxt = (op_q == OP_LW) ? S_WRITEBACK : S_FETCH;
        else if (wait_hit) state_nxt = S_ERROR;
      end
      S_WRITEBACK: state_nxt = S_FETCH;
      S_HALT:      state_nxt = S_HALT;
      S_ERROR:     state_nxt = S_ERROR;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Opcode to ALU control decode. Branches compare two registers, so they
  // keep alu_src=0 and use subtract.
  always_comb begin
    dec_alu_op   = 3'b000;
    dec_alu_src  = 1'b0;
    dec_reg_dest = 1'b0;
    case (op_q)
      OP_RTYPE: begin dec_alu_op = 3'b111; dec_reg_dest = 1'b1; end
      OP_ADDI:  begin dec_alu_op = 3'b000; dec_alu_src  = 1'b1; end
      OP_ANDI:  begin dec_alu_op = 3'b001; dec_alu_src  = 1'b1; end
      OP_ORI:   begin dec_alu_op = 3'b010; dec_alu_src  = 1'b1; end
      OP_NORI:  begin dec_alu_op = 3'b011; dec_alu_src  = 1'b1; end
      OP_SLTI:  begin dec_alu_op = 3'b101; dec_alu_src  = 1'b1; end
      OP_BEQ,
      OP_BNE:   begin dec_alu_op = 3'b100; end
      OP_LW,
      OP_SW:    begin dec_alu_op = 3'b000; dec_alu_src  = 1'b1; end
      default:  begin dec_alu_op = 3'b000; end
    endcase
  end

  // Output logic. Everything is a function of state/op_q except ir_load
  // (imem_ready), the NOP retire in DECODE (opcode is only latched at the end
  // of DECODE), the sw retire strobe (dmem_ready) and pc_src (zero).
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    reg_dest   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    error      = 1'b0;
    case (state)
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      S_DECODE: begin
        busy     = 1'b1;
        pc_write = dec_nop;
      end
      S_EXECUTE: begin
        busy     = 1'b1;
        alu_op   = dec_alu_op;
        alu_src  = dec_alu_src;
        reg_dest = dec_reg_dest;
        if (op_q == OP_BEQ) begin
          pc_write = 1'b1;
          pc_src   = zero;
        end else if (op_q == OP_BNE) begin
          pc_write = 1'b1;
          pc_src   = ~zero;
        end
      end
      S_MEM: begin
        busy      = 1'b1;
        alu_op    = dec_alu_op;
        alu_src   = dec_alu_src;
        reg_dest  = dec_reg_dest;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        pc_write  = (op_q == OP_SW) && dmem_ready;
      end
      S_WRITEBACK: begin
        busy       = 1'b1;
        alu_op     = dec_alu_op;
        alu_src    = dec_alu_src;
        reg_dest   = dec_reg_dest;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (op_q == OP_LW);
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: error  = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer (COUNT_WIDTH=2 so counter wrap is reachable).
// Each step carries its inputs and the expected output vector; steps are queued
// and then driven one per cycle, outputs compared at the falling edge.

module tb_multicycle_sequencer;

  localparam int CW = 2;
  localparam int TO = 15;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [3:0]    opcode;
  logic          zero;
  logic          imem_ready;
  logic          dmem_ready;
  logic          imem_req, ir_load, reg_dest, alu_src;
  logic [2:0]    alu_op;
  logic          mem_read, mem_write, mem_to_reg, reg_write, pc_write, pc_src;
  logic          busy, halted, error;
  logic [CW-1:0] instr_count;

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic       reg_dest;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic       pc_src;
    logic       busy;
    logic       halted;
    logic       error;
    logic [1:0] cnt;
  } ovec_t;

  typedef struct {
    logic       start;
    logic [3:0] opcode;
    logic       zero;
    logic       ir;
    logic       dr;
    ovec_t      exp;
  } step_t;

  step_t sq[$];
  int    errors = 0;
  int    checks = 0;
  ovec_t obs;

  multicycle_sequencer #(.COUNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .reg_dest(reg_dest), .alu_src(alu_src),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_write(pc_write),
    .pc_src(pc_src), .busy(busy), .halted(halted), .error(error),
    .instr_count(instr_count)
  );

  assign obs = '{imem_req: imem_req, ir_load: ir_load, reg_dest: reg_dest,
                 alu_src: alu_src, alu_op: alu_op, mem_read: mem_read,
                 mem_write: mem_write, mem_to_reg: mem_to_reg,
                 reg_write: reg_write, pc_write: pc_write, pc_src: pc_src,
                 busy: busy, halted: halted, error: error, cnt: instr_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- expected-output model ----------------
  function automatic ovec_t v_idle(input int c);
    ovec_t v = '0;
    v.cnt = 2'(c);
    return v;
  endfunction

  function automatic ovec_t v_fetch(input logic rdy, input int c);
    ovec_t v = v_idle(c);
    v.busy = 1'b1; v.imem_req = 1'b1; v.ir_load = rdy;
    return v;
  endfunction

  function automatic ovec_t v_dec(input int c, input logic nop);
    ovec_t v = v_idle(c);
    v.busy = 1'b1; v.pc_write = nop;
    return v;
  endfunction

  function automatic ovec_t v_alu(input logic [3:0] op, input int c);
    ovec_t v = v_idle(c);
    v.busy = 1'b1;
    case (op)
      4'b0000: begin v.alu_op = 3'b111; v.reg_dest = 1'b1; end
      4'b0001: begin v.alu_op = 3'b000; v.alu_src = 1'b1; end
      4'b0010: begin v.alu_op = 3'b001; v.alu_src = 1'b1; end
      4'b0011: begin v.alu_op = 3'b010; v.alu_src = 1'b1; end
      4'b0100: begin v.alu_op = 3'b011; v.alu_src = 1'b1; end
      4'b0111: begin v.alu_op = 3'b101; v.alu_src = 1'b1; end
      4'b0101, 4'b0110: v.alu_op = 3'b100;
      4'b1000, 4'b1001: begin v.alu_op = 3'b000; v.alu_src = 1'b1; end
      default: v.alu_op = 3'b000;
    endcase
    return v;
  endfunction

  function automatic ovec_t v_exec(input logic [3:0] op, input logic z, input int c);
    ovec_t v = v_alu(op, c);
    if (op == 4'b0101) begin v.pc_write = 1'b1; v.pc_src = z;  end
    if (op == 4'b0110) begin v.pc_write = 1'b1; v.pc_src = ~z; end
    return v;
  endfunction

  function automatic ovec_t v_mem(input logic [3:0] op, input logic dr, input int c);
    ovec_t v = v_alu(op, c);
    v.mem_read  = (op == 4'b1000);
    v.mem_write = (op == 4'b1001);
    v.pc_write  = (op == 4'b1001) && dr;
    return v;
  endfunction

  function automatic ovec_t v_wb(input logic [3:0] op, input int c);
    ovec_t v = v_alu(op, c);
    v.reg_write = 1'b1; v.pc_write = 1'b1;
    v.mem_to_reg = (op == 4'b1000);
    return v;
  endfunction

  function automatic ovec_t v_halt(input int c);
    ovec_t v = v_idle(c);
    v.halted = 1'b1;
    return v;
  endfunction

  function automatic ovec_t v_err(input int c);
    ovec_t v = v_idle(c);
    v.error = 1'b1;
    return v;
  endfunction

  // ---------------- scoreboard plumbing ----------------
  task automatic push(input logic st, input logic [3:0] op, input logic z,
                      input logic ir, input logic dr, input ovec_t e);
    step_t s;
    s.start = st; s.opcode = op; s.zero = z; s.ir = ir; s.dr = dr; s.exp = e;
    sq.push_back(s);
  endtask

  task automatic check(input string tag, input int n, input ovec_t got, input ovec_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed=%h expected=%h", tag, n, got, exp);
    end
  endtask

  task automatic run(input string tag);
    step_t s;
    int    n = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      start = s.start; opcode = s.opcode; zero = s.zero;
      imem_ready = s.ir; dmem_ready = s.dr;
      @(negedge clk);
      check(tag, n, obs, s.exp);
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; opcode = 4'b0000; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    do_reset();

    // Reset state, then R-type: FETCH, DECODE, EXECUTE, WRITEBACK.
    push(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, v_idle(0));
    push(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, v_idle(0));
    push(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, v_fetch(1'b1, 0));
    push(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, v_dec(0, 1'b0));
    push(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, v_exec(4'b0000, 1'b0, 0));
    push(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, v_wb(4'b0000, 0));
    run("rtype");

    // lw with three dmem wait cycles: 8 cycles total.
    push(1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, v_fetch(1'b1, 1));
    push(1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, v_dec(1, 1'b0));
    push(1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, v_exec(4'b1000, 1'b0, 1));
    for (int i = 0; i < 3; i++)
      push(1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, v_mem(4'b1000, 1'b0, 1));
    push(1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, v_mem(4'b1000, 1'b1, 1));
    push(1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, v_wb(4'b1000, 1));
    run("lw_wait");

    // beq taken, then bne not taken (zero=1 both); counter wraps 3 -> 0.
    push(1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, v_fetch(1'b1, 2));
    push(1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, v_dec(2, 1'b0));
    push(1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, v_exec(4'b0101, 1'b1, 2));
    push(1'b0, 4'b0110, 1'b1, 1'b1, 1'b1, v_fetch(1'b1, 3));
    push(1'b0, 4'b0110, 1'b1, 1'b1, 1'b1, v_dec(3, 1'b0));
    push(1'b0, 4'b0110, 1'b1, 1'b1, 1'b1, v_exec(4'b0110, 1'b1, 3));
    run("branch");

    // addi and slti, then instruction fetch timeout into ERROR.
    push(1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, v_fetch(1'b1, 0));
    push(1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, v_dec(0, 1'b0));
    push(1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, v_exec(4'b0001, 1'b0, 0));
    push(1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, v_wb(4'b0001, 0));
    push(1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, v_fetch(1'b1, 1));
    push(1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, v_dec(1, 1'b0));
    push(1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, v_exec(4'b0111, 1'b0, 1));
    push(1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, v_wb(4'b0111, 1));
    for (int i = 0; i < TO; i++)
      push(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, v_fetch(1'b0, 2));
    for (int i = 0; i < 3; i++)
      push(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, v_err(2));
    run("itype_imem_timeout");

    // sw then halt.
    do_reset();
    push(1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, v_idle(0));
    push(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, v_fetch(1'b1, 0));
    push(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, v_dec(0, 1'b0));
    push(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, v_exec(4'b1001, 1'b0, 0));
    push(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, v_mem(4'b1001, 1'b1, 0));
    push(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, v_fetch(1'b1, 1));
    push(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, v_dec(1, 1'b0));
    for (int i = 0; i < 3; i++)
      push(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, v_halt(1));
    run("sw_halt");

    // Four NOPs (counter 1,2,3,0), then lw with dmem timeout.
    do_reset();
    push(1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, v_idle(0));
    for (int i = 0; i < 4; i++) begin
      logic [3:0] nop_op;
      nop_op = (i == 3) ? 4'b1110 : 4'(10 + i);
      push(1'b0, nop_op, 1'b0, 1'b1, 1'b1, v_fetch(1'b1, i));
      push(1'b0, nop_op, 1'b0, 1'b1, 1'b1, v_dec(i, 1'b1));
    end
    push(1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, v_fetch(1'b1, 0));
    push(1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, v_dec(0, 1'b0));
    push(1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, v_exec(4'b1000, 1'b0, 0));
    for (int i = 0; i < TO; i++)
      push(1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, v_mem(4'b1000, 1'b0, 0));
    push(1'b1, 4'b1000, 1'b0, 1'b1, 1'b1, v_err(0));
    run("nop_wrap_dmem_timeout");

    // sw stalled in MEM, then asynchronous reset mid-cycle.
    do_reset();
    push(1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, v_idle(0));
    push(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, v_fetch(1'b1, 0));
    push(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, v_dec(0, 1'b0));
    push(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, v_exec(4'b1001, 1'b0, 0));
    push(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, v_mem(4'b1001, 1'b0, 0));
    push(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, v_mem(4'b1001, 1'b0, 0));
    run("sw_stall");
    dmem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, obs, v_idle(0));
    #10;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
